pll_phase_ctrl: RTL and testbench
=================================

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 Parameter CNT, default 5'd1: PLL counter index driven on cntsel; selects which output clock gets shifted.
REQ-002 Parameter STEP_W, default 10: width of signed phase-offset values in PLL phase steps.
REQ-003 Parameter TMO, default 255: scanclk cycles to wait on each phase_done edge before timeout.
REQ-004 scanclk  in  1  sole clock; all logic rising-edge on scanclk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 pll_locked  in  1  PLL locked status, asynchronous; synchronized internally.
REQ-007 req  in  1  request to move to target; sampled only in IDLE.
REQ-008 target  in  STEP_W  signed absolute phase offset in steps; captured with req.
REQ-009 ack  out  1  one-cycle pulse when requested offset is reached.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 current  out  STEP_W  signed offset applied so far, relative to the power-up phase.
REQ-012 error  out  1  sticky fault flag; cleared on the next accepted req.
REQ-013 phase_en  out  1  PLL phase-step enable.
REQ-014 updn  out  1  step direction to PLL: 1 = advance (+1), 0 = retard (-1).
REQ-015 cntsel  out  5  PLL counter select; constant CNT.
REQ-016 phase_done  in  1  PLL step-complete, active-high when idle; synchronized internally with 2 flops.

Function
REQ-017 FSM states: IDLE, PULSE, WAIT_LO, WAIT_HI, CHECK, DONE; ERR exists only per REQ-031.
REQ-018 IDLE: req=1 and locked_s=1 -> capture target into tgt and clear error -> CHECK. req with locked_s=0 -> ignored and error=1.
REQ-019 CHECK: tgt==current -> DONE. Otherwise updn = (tgt>current), held constant through the step -> PULSE.
REQ-020 PULSE: phase_en=1 for exactly 2 scanclk cycles -> WAIT_LO.
REQ-021 WAIT_LO: wait for synchronized phase_done=0 -> WAIT_HI.
REQ-022 WAIT_HI: wait for synchronized phase_done=1. Then current += 1 if updn=1, else current -= 1 (two's complement). Next state CHECK.
REQ-023 DONE: ack=1 for one cycle -> IDLE. Zero-step request (target==current) acks 2 cycles after req.
REQ-024 current saturates: no step beyond +2^(STEP_W-1)-1 or below -2^(STEP_W-1). When saturated, CHECK treats tgt as reached and goes to DONE.
REQ-025 Each step is issued only after the previous step's phase_done rise. There is never more than one step outstanding.
REQ-026 Loss of lock: locked_s falling in any non-IDLE state -> phase_en=0, current=0, error=1, no ack, -> IDLE next cycle. Loss of lock in IDLE -> current=0.
REQ-027 req while busy is ignored. The requester holds req until ack or error.
REQ-028 Outputs are registered: phase_en, updn, ack, busy, error.

Reset
REQ-029 rst_n low -> state IDLE, phase_en=0, updn=0, ack=0, busy=0, error=0, current=0, tgt=0, synchronizers=0, timeout counter=0.
REQ-030 Reset assertion mid-step abandons the step immediately. current after reset reflects the PLL's reset phase.

Configuration
REQ-031 Macro PLL_PHASE_TIMEOUT_EN defined:
- an 8-bit counter runs in WAIT_LO and WAIT_HI and is cleared on each state entry.
- reaching TMO -> ERR: error=1, phase_en=0, current unchanged.
- ERR -> IDLE the next cycle, no ack.
REQ-032 Macro undefined: no counter and no ERR state; WAIT_LO and WAIT_HI wait indefinitely, subject only to REQ-026.

Verification
REQ-033 Locked; req with target=+3; PLL model drops phase_done 2 cycles after phase_en and restores it 4 cycles later -> three 2-cycle phase_en pulses with updn=1, current 0->1->2->3, one ack, busy falls with ack.
REQ-034 From current=3, target=-2 -> five pulses with updn=0, current ends at -2, one ack.
REQ-035 target equal to current (5 and 5) -> no phase_en, ack 2 cycles after req.
REQ-036 pll_locked dropped during the second step of target=+4 -> phase_en=0 within 3 cycles, current=0, error=1, no ack; next req clears error.
REQ-037 PLL_PHASE_TIMEOUT_EN defined, phase_done held high after phase_en -> ERR after 255 cycles in WAIT_LO, error=1, current unchanged, no ack; macro undefined -> FSM remains in WAIT_LO.
REQ-038 STEP_W=4, current=7, target=+7 requested after target=-8 path -> current reaches -8 and stops; a further target below -8 is unrepresentable, so target=7 from -8 gives 15 steps.

Source files
------------

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: steps a PLL output clock phase one step at a time toward a signed target offset.
// Optional phase_done timeout with ERR state when PLL_PHASE_TIMEOUT_EN is defined.
module pll_phase_ctrl #(
  parameter logic [4:0] CNT = 5'd1,
  parameter int STEP_W = 10,
  parameter int TMO = 255
) (
  input  logic                     scanclk,
  input  logic                     rst_n,
  input  logic                     pll_locked,
  input  logic                     req,
  input  logic signed [STEP_W-1:0] target,
  output logic                     ack,
  output logic                     busy,
  output logic signed [STEP_W-1:0] current,
  output logic                     error,
  output logic                     phase_en,
  output logic                     updn,
  output logic [4:0]               cntsel,
  input  logic                     phase_done
);
  typedef enum logic [2:0] {
    IDLE, PULSE, WAIT_LO, WAIT_HI, CHECK, DONE
`ifdef PLL_PHASE_TIMEOUT_EN
    , ERR
`endif
  } state_t;
  localparam logic signed [STEP_W-1:0] MAX = {1'b0, {(STEP_W-1){1'b1}}};
  localparam logic signed [STEP_W-1:0] MIN = {1'b1, {(STEP_W-1){1'b0}}};
  localparam logic signed [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};
  state_t state, state_n;
  logic [1:0] lk_sync, pd_sync;
  logic locked_s, pd_s, pcnt, up, at_tgt;
  logic signed [STEP_W-1:0] tgt;
`ifdef PLL_PHASE_TIMEOUT_EN
  logic [7:0] tcnt;
`endif
  assign cntsel = CNT;
  assign locked_s = lk_sync[1];
  assign pd_s = pd_sync[1];
  assign up = tgt > current;
  // a saturated counter can never reach the target, so treat it as reached
  assign at_tgt = (tgt == current) || (up && current == MAX) || (!up && current == MIN);
  always_comb begin
    state_n = state;
    if (state != IDLE && !locked_s) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = (req && locked_s) ? CHECK : IDLE;
        CHECK:   state_n = at_tgt ? DONE : PULSE;
        PULSE:   state_n = pcnt ? WAIT_LO : PULSE;
`ifdef PLL_PHASE_TIMEOUT_EN
        WAIT_LO: state_n = !pd_s ? WAIT_HI : (tcnt == 8'(TMO)) ? ERR : WAIT_LO;
        WAIT_HI: state_n = pd_s ? CHECK : (tcnt == 8'(TMO)) ? ERR : WAIT_HI;
`else
        WAIT_LO: state_n = !pd_s ? WAIT_HI : WAIT_LO;
        WAIT_HI: state_n = pd_s ? CHECK : WAIT_HI;
`endif
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge scanclk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      lk_sync  <= '0;
      pd_sync  <= '0;
      phase_en <= 1'b0;
      updn     <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      current  <= '0;
      tgt      <= '0;
      pcnt     <= 1'b0;
`ifdef PLL_PHASE_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      lk_sync  <= {lk_sync[0], pll_locked};
      pd_sync  <= {pd_sync[0], phase_done};
      state    <= state_n;
      phase_en <= state_n == PULSE;
      ack      <= state_n == DONE;
      busy     <= state_n != IDLE;
      pcnt     <= state == PULSE && state_n == PULSE;
      if (state == IDLE && req && locked_s) begin
        tgt   <= target;
        error <= 1'b0;
      end
      if (state == IDLE && req && !locked_s) error <= 1'b1;
      if (state != IDLE && !locked_s) error <= 1'b1;
      if (state == CHECK && !at_tgt) updn <= up;
      if (!locked_s) current <= '0;
      else if (state == WAIT_HI && pd_s) current <= updn ? current + ONE : current - ONE;
`ifdef PLL_PHASE_TIMEOUT_EN
      tcnt <= (state_n == state && (state == WAIT_LO || state == WAIT_HI)) ? tcnt + 8'd1 : 8'd0;
      if (state_n == ERR) error <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: directed bench for pll_phase_ctrl (STEP_W=4) with a simple PLL phase_done model.
module tb_pll_phase_ctrl;
  logic scanclk = 0, rst_n = 0, pll_locked = 0, req = 0, phase_done = 1;
  logic ack, busy, error, phase_en, updn;
  logic signed [3:0] target = 0, current;
  logic [4:0] cntsel;
  int checks = 0, errors = 0, pe_rises = 0, acks = 0, pe_len = 0;
  logic exp_dir = 0, model_on = 1;

  pll_phase_ctrl #(.STEP_W(4)) dut (
    .scanclk(scanclk), .rst_n(rst_n), .pll_locked(pll_locked), .req(req), .target(target),
    .ack(ack), .busy(busy), .current(current), .error(error), .phase_en(phase_en),
    .updn(updn), .cntsel(cntsel), .phase_done(phase_done)
  );

  always #5 scanclk = ~scanclk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // PLL model: phase_done low 2 cycles after phase_en, back high 4 cycles later
  always @(posedge scanclk) begin
    #1;
    if (phase_en && model_on) begin
      repeat (2) @(posedge scanclk);
      #1 phase_done = 0;
      repeat (4) @(posedge scanclk);
      #1 phase_done = 1;
    end
  end

  always @(negedge scanclk) begin
    if (phase_en) begin
      if (pe_len == 0) begin
        pe_rises++;
        chk("updn_dir", updn, exp_dir);
      end
      pe_len++;
    end else if (pe_len != 0) begin
      chk("pe_width", pe_len, 2);
      pe_len = 0;
    end
    if (ack) acks++;
  end

  task automatic do_req(input string tag, input logic signed [3:0] t, input int steps, input logic dir);
    pe_rises = 0; acks = 0; exp_dir = dir; req = 1; target = t;
    for (int i = 0; i < 3000 && !ack; i++) begin @(posedge scanclk); #1; end
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_busy_at_ack"}, busy, 1);
    chk({tag, "_error"}, error, 0);
    req = 0;
    @(posedge scanclk); #1;
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_ack_pulse"}, ack, 0);
    repeat (3) @(posedge scanclk); #1;
    chk({tag, "_steps"}, pe_rises, steps);
    chk({tag, "_acks"}, acks, 1);
    chk({tag, "_current"}, current, t);
  endtask

  initial begin
    repeat (3) @(posedge scanclk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_error", error, 0);
    chk("rst_phase_en", phase_en, 0);
    chk("rst_updn", updn, 0);
    chk("rst_current", current, 0);
    chk("cntsel", cntsel, 1);
    rst_n = 1;
    req = 1; target = 2;
    @(posedge scanclk); #1;
    chk("nolock_error", error, 1);
    chk("nolock_busy", busy, 0);
    req = 0; pll_locked = 1;
    repeat (4) @(posedge scanclk); #1;
    pe_rises = 0; acks = 0; exp_dir = 1; req = 1; target = 4;
    for (int i = 0; i < 500 && pe_rises < 2; i++) @(negedge scanclk);
    chk("ll_second_step", pe_rises, 2);
    pll_locked = 0;
    repeat (3) @(posedge scanclk); #1;
    chk("ll_phase_en", phase_en, 0);
    chk("ll_current", current, 0);
    chk("ll_error", error, 1);
    chk("ll_busy", busy, 0);
    req = 0; pll_locked = 1;
    repeat (12) @(posedge scanclk); #1;
    chk("ll_no_ack", acks, 0);
    do_req("up3", 4'sd3, 3, 1);
    do_req("dn_m2", -4'sd2, 5, 0);
    do_req("to5", 4'sd5, 7, 1);
    pe_rises = 0; acks = 0; req = 1; target = 5;
    @(posedge scanclk); #1;
    chk("zero_ack_early", ack, 0);
    @(posedge scanclk); #1;
    chk("zero_ack", ack, 1);
    req = 0;
    repeat (3) @(posedge scanclk); #1;
    chk("zero_steps", pe_rises, 0);
    chk("zero_acks", acks, 1);
    chk("zero_current", current, 5);
    do_req("to_m8", -4'sd8, 13, 0);
    do_req("m8_to7", 4'sd7, 15, 1);
    model_on = 0; pe_rises = 0; acks = 0; exp_dir = 0; req = 1; target = 6;
`ifdef PLL_PHASE_TIMEOUT_EN
    for (int i = 0; i < 400 && !error; i++) begin @(posedge scanclk); #1; end
    req = 0;
    chk("tmo_error", error, 1);
    @(posedge scanclk); #1;
    chk("tmo_busy", busy, 0);
    chk("tmo_current", current, 7);
    chk("tmo_acks", acks, 0);
    chk("tmo_steps", pe_rises, 1);
`else
    repeat (300) @(posedge scanclk); #1;
    chk("hang_busy", busy, 1);
    chk("hang_current", current, 7);
    chk("hang_acks", acks, 0);
    chk("hang_steps", pe_rises, 1);
    pll_locked = 0; req = 0;
    repeat (4) @(posedge scanclk); #1;
    chk("hang_ll_error", error, 1);
    chk("hang_ll_current", current, 0);
    chk("hang_ll_busy", busy, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
